// File: rtl/alu_pkg.sv
// Shared opcodes, condition-code bit positions and FSM encoding for the Y86 execute ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SAR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LastCnt);
  // Combinational so the final partial sum is presented in the cycle done_o is high.
  assign product_o = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Y86 execute-stage ALU with valid/ready handshakes, registered result and ZF/SF/OF flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic [2:0]       cc
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept, set_cc_q, mul_start, mul_busy, mul_done, alu_of;
  logic [WIDTH-1:0] alu_res, mul_prod, val_e_q, val_e_d;
  logic [2:0]       cc_q, cc_d;
  logic [SHW-1:0]   shamt;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign shamt     = valA[SHW-1:0];

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock    (clock),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (valA),
    .b_i      (valB),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = valA + valB;
        alu_of  = (valA[WIDTH-1] == valB[WIDTH-1]) && (alu_res[WIDTH-1] != valA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = valB - valA;
        alu_of  = (valA[WIDTH-1] != valB[WIDTH-1]) && (alu_res[WIDTH-1] != valB[WIDTH-1]);
      end
      OP_AND:  alu_res = valA & valB;
      OP_XOR:  alu_res = valA ^ valB;
      OP_OR:   alu_res = valA | valB;
      OP_SHL:  alu_res = valB << shamt;
      OP_SAR:  alu_res = $signed(valB) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (op == OP_MUL) ? StMul : StDone;
      // Losing busy without done can only follow a glitch; recover rather than hang.
      StMul: begin
        if (mul_done)      state_d = StDone;
        else if (!mul_busy) state_d = StIdle;
      end
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    val_e_d = val_e_q;
    cc_d    = cc_q;
    if (accept && (op != OP_MUL)) begin
      val_e_d = alu_res;
      if (set_cc) begin
        cc_d[CC_ZF] = (alu_res == '0);
        cc_d[CC_SF] = alu_res[WIDTH-1];
        cc_d[CC_OF] = alu_of;
      end
    end else if ((state_q == StMul) && mul_done) begin
      val_e_d = mul_prod;
      if (set_cc_q) begin
        cc_d[CC_ZF] = (mul_prod == '0);
        cc_d[CC_SF] = mul_prod[WIDTH-1];
        cc_d[CC_OF] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      val_e_q  <= '0;
      cc_q     <= 3'b100;
      set_cc_q <= 1'b0;
    end else begin
      val_e_q <= val_e_d;
      cc_q    <= cc_d;
      if (accept) set_cc_q <= set_cc;
    end
  end

  assign valE = val_e_q;
  assign cc   = cc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, in_valid, in_ready, set_cc, out_valid, out_ready;
  logic [2:0]   op, cc;
  logic [W-1:0] valA, valB, valE;
  logic [2:0]   m_cc;
  int           n_checks = 0;
  int           n_err = 0;

  always #5 clock = ~clock;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .valA     (valA),
    .valB     (valB),
    .set_cc   (set_cc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .valE     (valE),
    .cc       (cc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic of);
    logic [63:0] p;
    of = 1'b0;
    case (o)
      3'd0: begin r = a + b; of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin r = b - a; of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: r = b << (a % W);
      3'd6: r = $signed(b) >>> (a % W);
      default: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_cc = 3'b100;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sc, input int hold);
    logic [W-1:0] er;
    logic         eof;
    int           lat, low, exp_lat;
    model(o, a, b, er, eof);
    if (sc) m_cc = {er == '0, er[W-1], eof};
    exp_lat = (o == 3'd7) ? W + 1 : 1;
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    op = o; valA = a; valB = b; set_cc = sc; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clock);
    #1;
    // Scramble inputs after accept: the DUT must have captured them.
    in_valid = 1'b0; op = 3'($urandom); valA = $urandom; valB = $urandom; set_cc = 1'($urandom);
    lat = 0; low = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!in_ready) low++;
    end while (!out_valid && lat < 100);
    check("latency", lat, exp_lat);
    check("in_ready_low", low, exp_lat);
    check("valE", valE, er);
    check("cc", cc, m_cc);
    if (lat >= 100) begin
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("hold_valid", out_valid, 1);
      check("hold_valE", valE, er);
      check("hold_cc", cc, m_cc);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; op = '0; valA = '0; valB = '0; set_cc = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_cc = 3'b100;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_valE", valE, 0);
    check("rst_cc", cc, 3'b100);

    do_op(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 0);
    check("add_of_valE", valE, 32'h8000_0000);
    check("add_of_cc", cc, 3'b011);
    do_op(3'd1, 32'd5, 32'd5, 1'b1, 0);
    check("sub_zero_valE", valE, 0);
    check("sub_zero_cc", cc, 3'b100);
    do_op(3'd3, 32'd1, 32'd1, 1'b0, 0);
    check("xor_nocc_cc", cc, 3'b100);
    do_op(3'd7, 32'd3, 32'hFFFF_FFFF, 1'b1, 0);
    check("mul_valE", valE, 32'hFFFF_FFFD);
    check("mul_cc", cc, 3'b010);
    do_op(3'd6, 32'd4, 32'h8000_0000, 1'b0, 0);
    check("sar_valE", valE, 32'hF800_0000);
    do_op(3'd5, 32'd33, 32'd1, 1'b0, 0);
    check("shl_wrap_valE", valE, 32'h2);
    do_op(3'd0, 32'd10, 32'd20, 1'b1, 5);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 70)) : W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
      do_op(ro, ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a multiply: nothing may emerge afterwards.
    @(negedge clock);
    op = 3'd7; valA = 32'd7; valB = 32'd9; set_cc = 1'b1; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_cc = 3'b100;
    check("midmul_out_valid", out_valid, 0);
    check("midmul_in_ready", in_ready, 1);
    check("midmul_valE", valE, 0);
    check("midmul_cc", cc, 3'b100);
    repeat (30) @(negedge clock);
    check("midmul_no_late_result", out_valid, 0);
    do_op(3'd0, 32'd2, 32'd2, 1'b1, 0);
    check("post_reset_add", valE, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
